// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for the 1024:1 mux tree: sweeps a wrapping window of select
// values, samples the tree output once per select and packs the bits LSB-first into bytes.
module mux_scan_sequencer #(
  parameter int unsigned SEL_W = 10,
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SEL_W-1:0] base_sel,
  input  logic [CNT_W-1:0] num_samples,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int unsigned MAX_CNT_I = 1 << SEL_W;
  localparam logic [CNT_W-1:0] MAX_CNT = MAX_CNT_I[CNT_W-1:0];

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;

  logic             accept;
  logic [CNT_W-1:0] idx_next;
  logic             last_sample;
  logic             completes;
  logic             allow;
  logic [7:0]       sample_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    count_d      = count_q;
    idx_d        = idx_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;

    accept      = byte_valid_q && byte_ready;
    idx_next    = idx_q + CNT_W'(1);
    last_sample = (idx_next == count_q);
    completes   = (bit_cnt_q == 3'd7) || last_sample;
    sample_byte = shreg_q | (8'(mux_out) << bit_cnt_q);
    // A completing sample may only proceed if the output register frees up this edge.
    allow       = !(completes && byte_valid_q && !byte_ready);

    if (accept) begin
      byte_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_samples == '0) begin
            state_d = S_DONE;
          end else begin
            count_d   = (num_samples > MAX_CNT) ? MAX_CNT : num_samples;
            sel_d     = base_sel;
            idx_d     = '0;
            bit_cnt_d = '0;
            shreg_d   = '0;
            state_d   = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (allow) begin
          idx_d = idx_next;
          if (completes) begin
            byte_out_d   = sample_byte;
            byte_valid_d = 1'b1;
            shreg_d      = '0;
            bit_cnt_d    = '0;
          end else begin
            shreg_d   = sample_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (last_sample) begin
            state_d = S_DRAIN;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (accept) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      sel_d        = sel_q;
      count_d      = '0;
      idx_d        = '0;
      bit_cnt_d    = '0;
      shreg_d      = '0;
      byte_valid_d = 1'b0;
    end
  end

  assign sel        = sel_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign busy       = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: table of scans plus backpressure,
// abort and mid-scan reset sequences, against a behavioural mux tree.
module tb_mux_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [9:0]  base_sel;
  logic [10:0] num_samples;
  logic [9:0]  sel;
  logic        mux_out;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;

  logic [1023:0] tree_in;

  int tests;
  int failed;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] num;
    int          pat;
    int          exp_bytes;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs[10];

  mux_scan_sequencer #(.SEL_W(10), .CNT_W(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_sel   (base_sel),
    .num_samples(num_samples),
    .sel        (sel),
    .mux_out    (mux_out),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  assign mux_out = tree_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0: in[k]=k&1, 1: all ones, 2: in[k]=(k%3==0), 3: in[k]=~k&1
  task automatic set_pattern(input int pat);
    for (int k = 0; k < 1024; k++) begin
      case (pat)
        0:       tree_in[k] = k[0];
        1:       tree_in[k] = 1'b1;
        2:       tree_in[k] = ((k % 3) == 0);
        default: tree_in[k] = ~k[0];
      endcase
    end
  endtask

  task automatic next_window();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int n, t, nb, sel_err, busy_cnt, done_cnt, done_t, exp_done_t;
    logic [7:0] first_b, last_b;
    logic [9:0] exp_sel;
    n = (v.num > 11'd1024) ? 1024 : int'(v.num);
    exp_done_t = (n == 0) ? 0 : n + 1;
    set_pattern(v.pat);
    byte_ready  = 1'b1;
    base_sel    = v.base;
    num_samples = v.num;
    start       = 1'b1;
    next_window();
    start = 1'b0;
    t = 0; nb = 0; sel_err = 0; busy_cnt = 0; done_cnt = 0; done_t = -1;
    first_b = '0; last_b = '0;
    while (t < 3000) begin
      if (busy) busy_cnt++;
      exp_sel = v.base + 10'(t);
      if (t < n && sel !== exp_sel) sel_err++;
      if (byte_valid && byte_ready) begin
        if (nb == 0) first_b = byte_out;
        last_b = byte_out;
        nb++;
      end
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (done_t >= 0 && t >= done_t + 2) break;
      next_window();
      t++;
    end
    check($sformatf("v%0d_done_time", id), 32'(done_t), 32'(exp_done_t));
    check($sformatf("v%0d_done_pulses", id), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d_bytes", id), 32'(nb), 32'(v.exp_bytes));
    check($sformatf("v%0d_busy_cycles", id), 32'(busy_cnt), 32'((n == 0) ? 0 : n + 1));
    check($sformatf("v%0d_sel_errors", id), 32'(sel_err), 32'd0);
    if (v.exp_bytes > 0) begin
      check($sformatf("v%0d_first_byte", id), 32'(first_b), 32'(v.exp_first));
      check($sformatf("v%0d_last_byte", id), 32'(last_b), 32'(v.exp_last));
    end
  endtask

  initial begin
    int sel_err, done_cnt;
    tests = 0; failed = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; byte_ready = 1'b1;
    base_sel = '0; num_samples = '0; tree_in = '0;

    vecs[0] = '{base: 10'd0,    num: 11'd8,    pat: 0, exp_bytes: 1,   exp_first: 8'hAA, exp_last: 8'hAA};
    vecs[1] = '{base: 10'd1,    num: 11'd8,    pat: 0, exp_bytes: 1,   exp_first: 8'h55, exp_last: 8'h55};
    vecs[2] = '{base: 10'd1022, num: 11'd3,    pat: 3, exp_bytes: 1,   exp_first: 8'h05, exp_last: 8'h05};
    vecs[3] = '{base: 10'd5,    num: 11'd16,   pat: 1, exp_bytes: 2,   exp_first: 8'hFF, exp_last: 8'hFF};
    vecs[4] = '{base: 10'd0,    num: 11'd12,   pat: 2, exp_bytes: 2,   exp_first: 8'h49, exp_last: 8'h02};
    vecs[5] = '{base: 10'd1020, num: 11'd10,   pat: 3, exp_bytes: 2,   exp_first: 8'h55, exp_last: 8'h01};
    vecs[6] = '{base: 10'd0,    num: 11'd2000, pat: 1, exp_bytes: 128, exp_first: 8'hFF, exp_last: 8'hFF};
    vecs[7] = '{base: 10'd512,  num: 11'd1024, pat: 0, exp_bytes: 128, exp_first: 8'hAA, exp_last: 8'hAA};
    vecs[8] = '{base: 10'd7,    num: 11'd1,    pat: 0, exp_bytes: 1,   exp_first: 8'h01, exp_last: 8'h01};
    vecs[9] = '{base: 10'd300,  num: 11'd0,    pat: 0, exp_bytes: 0,   exp_first: 8'h00, exp_last: 8'h00};

    #1 rst = 1'b1;
    #1;
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_byte_out", 32'(byte_out), 32'd0);
    check("reset_byte_valid", 32'(byte_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    next_window();
    next_window();
    rst = 1'b0;
    next_window();

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: first byte held, sel stalls on the byte-completing sample.
    set_pattern(1);
    byte_ready = 1'b0; base_sel = 10'd0; num_samples = 11'd16; start = 1'b1;
    next_window();
    start = 1'b0;
    for (int t = 1; t <= 8; t++) next_window();
    check("bp_first_valid", 32'(byte_valid), 32'd1);
    check("bp_first_byte", 32'(byte_out), 32'hFF);
    sel_err = 0;
    for (int t = 9; t <= 29; t++) begin
      next_window();
      if (sel !== 10'((t < 15) ? t : 15)) sel_err++;
    end
    check("bp_sel_stall", 32'(sel_err), 32'd0);
    check("bp_held_valid", 32'(byte_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    next_window();
    byte_ready = 1'b1;
    next_window();
    check("bp_second_valid", 32'(byte_valid), 32'd1);
    check("bp_second_byte", 32'(byte_out), 32'hFF);
    next_window();
    check("bp_done", 32'(done), 32'd1);
    check("bp_done_valid", 32'(byte_valid), 32'd0);
    next_window();

    // Abort mid-scan while a byte is pending.
    set_pattern(0);
    byte_ready = 1'b0; base_sel = 10'd0; num_samples = 11'd20; start = 1'b1;
    next_window();
    start = 1'b0;
    for (int t = 1; t <= 12; t++) next_window();
    check("abort_pre_valid", 32'(byte_valid), 32'd1);
    check("abort_pre_sel", 32'(sel), 32'd12);
    abort = 1'b1;
    next_window();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(byte_valid), 32'd0);
    check("abort_sel_hold", 32'(sel), 32'd12);
    done_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      if (done) done_cnt++;
      next_window();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_vec(10, '{base: 10'd100, num: 11'd8, pat: 0, exp_bytes: 1, exp_first: 8'hAA, exp_last: 8'hAA});

    // Asynchronous reset with a byte pending; start ignored while in reset.
    set_pattern(1);
    byte_ready = 1'b0; base_sel = 10'd0; num_samples = 11'd16; start = 1'b1;
    next_window();
    start = 1'b0;
    for (int t = 1; t <= 10; t++) next_window();
    check("rst_pre_valid", 32'(byte_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_sel", 32'(sel), 32'd0);
    check("rst_async_byte", 32'(byte_out), 32'd0);
    check("rst_async_valid", 32'(byte_valid), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    base_sel = 10'd50; num_samples = 11'd8; start = 1'b1;
    next_window();
    check("rst_start_ignored_busy", 32'(busy), 32'd0);
    check("rst_start_ignored_sel", 32'(sel), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    next_window();
    check("rst_release_busy", 32'(busy), 32'd0);
    check("rst_release_done", 32'(done), 32'd0);
    byte_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
